mc_path_gen: RTL and testbench

Monte Carlo path generator for the option-pricing datapath. Holds N simulated underlying prices, advances each by one discretised geometric-Brownian step per simulated day, and streams each new price over a valid/ready handshake. Sits directly upstream of the pricing core, which consumes the 12-bit path samples. Gaussian noise is approximated on-chip from a 32-bit LFSR.

---
 rtl/mc_path_if.sv | 15 +
 rtl/mc_path_gen.sv | 196 +++++++++++++++++++
 tb/tb_mc_path_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_path_if.sv
// Sample stream between mc_path_gen (master) and the pricing core (slave):
// price, path index and day travel together under a valid/ready handshake.
interface mc_path_if #(
    parameter int W  = 12,
    parameter int IW = 7
);
    logic [W-1:0]  path;
    logic          path_valid;
    logic          path_ready;
    logic [IW-1:0] path_idx;
    logic [3:0]    day;

    modport master (output path, output path_valid, output path_idx, output day, input path_ready);
    modport slave  (input path, input path_valid, input path_idx, input day, output path_ready);
endinterface

// File: rtl/mc_path_gen.sv
// Monte Carlo GBM path generator: N prices advanced DAY steps each, streamed day-major.
// Build option MC_ANTITHETIC_EN: odd paths reuse the negated noise of the preceding even path.
//   state  | meaning
//   S_IDLE | waiting for start; the start cycle already produces beat (idx 0, day 0)
//   S_RUN  | producing beats whenever the output register is free or being accepted
//   S_DONE | one-cycle done pulse after the final handshake
module mc_path_gen #(
    parameter int N   = 128,
    parameter int DAY = 8,
    parameter int W   = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] s0,
    input  logic [11:0]  mu,
    input  logic [7:0]   sigma,
    input  logic [31:0]  seed,
    output logic         busy,
    output logic         done,
    mc_path_if.master    pif
);
    localparam int IW = $clog2(N);
    localparam int PW = W + 14;
    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_RUN     = 2'd1;
    localparam logic [1:0]    S_DONE    = 2'd2;
    localparam logic [31:0]   LFSR_MASK = 32'h8020_0003;
    localparam logic [PW-2:0] S_MAX     = (PW-1)'((1 << W) - 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [11:0]   mu_q, mu_d;
    logic [7:0]    sigma_q, sigma_d;
    logic [W-1:0]  s0_q, s0_d;
    logic [IW-1:0] nidx_q, nidx_d;
    logic [3:0]    nday_q, nday_d;
    logic          last_q, last_d;
    logic [W-1:0]  path_q, path_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] pidx_q, pidx_d;
    logic [3:0]    pday_q, pday_d;
`ifdef MC_ANTITHETIC_EN
    logic signed [10:0] zh_q, zh_d;
`endif
    logic [W-1:0]  mem_q [N];

    logic               idle, hs, beat, adv;
    logic [31:0]        src_lfsr;
    logic [11:0]        src_mu;
    logic [7:0]         src_sigma;
    logic [W-1:0]       src_s;
    logic [IW-1:0]      src_idx;
    logic [3:0]         src_day;
    logic [9:0]         byte_sum;
    logic signed [10:0] z_fresh, z_use;
    logic signed [19:0] sz;
    logic signed [12:0] step;
    logic signed [PW-1:0] s_ext, prod, s_sum;
    logic [W-1:0]       s_next;

    // In IDLE the first beat is computed straight from the start-cycle inputs.
    always_comb begin
        idle      = (state_q == S_IDLE);
        hs        = valid_q & pif.path_ready;
        beat      = idle ? start : ((state_q == S_RUN) && !last_q && (!valid_q || pif.path_ready));
        src_lfsr  = idle ? ((seed == 32'd0) ? 32'd1 : seed) : lfsr_q;
        src_mu    = idle ? mu : mu_q;
        src_sigma = idle ? sigma : sigma_q;
        src_idx   = idle ? '0 : nidx_q;
        src_day   = idle ? 4'd0 : nday_q;
        src_s     = idle ? s0 : ((nday_q == 4'd0) ? s0_q : mem_q[nidx_q]);
    end

    always_comb begin
        byte_sum = {2'b0, src_lfsr[7:0]} + {2'b0, src_lfsr[15:8]}
                 + {2'b0, src_lfsr[23:16]} + {2'b0, src_lfsr[31:24]};
        z_fresh  = $signed({1'b0, byte_sum}) - 11'sd510;
`ifdef MC_ANTITHETIC_EN
        z_use    = src_idx[0] ? -zh_q : z_fresh;
        adv      = !src_idx[0];
`else
        z_use    = z_fresh;
        adv      = 1'b1;
`endif
        sz     = $signed({12'b0, src_sigma}) * $signed({{9{z_use[10]}}, z_use});
        step   = 13'($signed({{8{src_mu[11]}}, src_mu}) + (sz >>> 9));
        s_ext  = $signed({14'b0, src_s});
        prod   = s_ext * $signed({{(PW-13){step[12]}}, step});
        s_sum  = s_ext + (prod >>> 12);
        if (s_sum[PW-1])
            s_next = '0;
        else if (s_sum[PW-2:0] > S_MAX)
            s_next = {W{1'b1}};
        else
            s_next = s_sum[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        mu_d    = mu_q;
        sigma_d = sigma_q;
        s0_d    = s0_q;
        nidx_d  = nidx_q;
        nday_d  = nday_q;
        last_d  = last_q;
        path_d  = path_q;
        valid_d = valid_q;
        pidx_d  = pidx_q;
        pday_d  = pday_q;
`ifdef MC_ANTITHETIC_EN
        zh_d    = zh_q;
        if (beat && adv)
            zh_d = z_fresh;
`endif
        if (idle && start) begin
            state_d = S_RUN;
            mu_d    = mu;
            sigma_d = sigma;
            s0_d    = s0;
        end
        if (beat) begin
            path_d  = s_next;
            valid_d = 1'b1;
            pidx_d  = src_idx;
            pday_d  = src_day;
            lfsr_d  = src_lfsr;
            if (adv)
                lfsr_d = src_lfsr[0] ? ((src_lfsr >> 1) ^ LFSR_MASK) : (src_lfsr >> 1);
            if (src_idx == IW'(N - 1)) begin
                nidx_d = '0;
                nday_d = src_day + 4'd1;
            end else begin
                nidx_d = src_idx + IW'(1);
                nday_d = src_day;
            end
            last_d = (src_idx == IW'(N - 1)) && (src_day == 4'(DAY - 1));
        end else if (hs) begin
            valid_d = 1'b0;
        end
        if ((state_q == S_RUN) && last_q && hs)
            state_d = S_DONE;
        if (state_q == S_DONE)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= 32'd1;
            mu_q    <= '0;
            sigma_q <= '0;
            s0_q    <= '0;
            nidx_q  <= '0;
            nday_q  <= '0;
            last_q  <= 1'b0;
            path_q  <= '0;
            valid_q <= 1'b0;
            pidx_q  <= '0;
            pday_q  <= '0;
`ifdef MC_ANTITHETIC_EN
            zh_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mu_q    <= mu_d;
            sigma_q <= sigma_d;
            s0_q    <= s0_d;
            nidx_q  <= nidx_d;
            nday_q  <= nday_d;
            last_q  <= last_d;
            path_q  <= path_d;
            valid_q <= valid_d;
            pidx_q  <= pidx_d;
            pday_q  <= pday_d;
`ifdef MC_ANTITHETIC_EN
            zh_q    <= zh_d;
`endif
        end
    end

    // Day 0 reads s0_q, so the price array never needs a bulk load.
    always_ff @(posedge clk) begin
        if (beat)
            mem_q[src_idx] <= s_next;
    end

    assign pif.path       = path_q;
    assign pif.path_valid = valid_q;
    assign pif.path_idx   = pidx_q;
    assign pif.day        = pday_q;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
endmodule

// File: tb/tb_mc_path_gen.sv
// Self-checking bench for mc_path_gen: randomized runs compared with a behavioural
// GBM path model written in plain integer arithmetic.
`timescale 1ns/1ps
module tb_mc_path_gen;
    localparam int N    = 128;
    localparam int DAY  = 8;
    localparam int W    = 12;
    localparam int IW   = $clog2(N);
    localparam int NB   = N * DAY;
    localparam int SMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] s0 = '0;
    logic [11:0]  mu = '0;
    logic [7:0]   sigma = '0;
    logic [31:0]  seed = '0;
    logic         busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_cyc = 0;
    int exp_path[NB], exp_idx[NB], exp_day[NB];
    int obs_path[NB], obs_idx[NB], obs_day[NB];

    mc_path_if #(.W(W), .IW(IW)) pif ();

    mc_path_gen #(.N(N), .DAY(DAY), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .s0(s0), .mu(mu), .sigma(sigma),
        .seed(seed), .busy(busy), .done(done), .pif(pif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int noise(input logic [31:0] l);
        return int'(l[7:0]) + int'(l[15:8]) + int'(l[23:16]) + int'(l[31:24]) - 510;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    endfunction

    // Whole-run reference: price table advanced day by day, day-major sample order.
    task automatic model_run(input int s0v, input int muv, input int sg, input logic [31:0] sd);
        int price[N];
        logic [31:0] l;
        int z, zp, s, st, k;
        l = (sd == 32'd0) ? 32'd1 : sd;
        zp = 0;
        k = 0;
        for (int d = 0; d < DAY; d++) begin
            for (int i = 0; i < N; i++) begin
                s = (d == 0) ? s0v : price[i];
`ifdef MC_ANTITHETIC_EN
                if (i % 2 == 1) z = -zp;
                else begin
                    z = noise(l);
                    zp = z;
                    l = lfsr_next(l);
                end
`else
                z = noise(l);
                l = lfsr_next(l);
`endif
                st = muv + fdiv(sg * z, 512);
                s = s + fdiv(s * st, 4096);
                if (s < 0) s = 0;
                if (s > SMAX) s = SMAX;
                price[i] = s;
                exp_path[k] = s;
                exp_idx[k] = i;
                exp_day[k] = d;
                k++;
            end
        end
    endtask

    task automatic do_start(input logic [W-1:0] s0v, input logic [11:0] muv,
                            input logic [7:0] sg, input logic [31:0] sd);
        @(negedge clk);
        s0 = s0v;
        mu = muv;
        sigma = sg;
        seed = sd;
        start = 1'b1;
        s_cyc = cyc;
    endtask

    // Drives path_ready, records accepted beats, counts protocol violations
    // (held beat changing/dropping during a stall, busy/valid at done).
    task automatic collect(input int stop_at, input int stall_pct, input int junk_at,
                           output int got, output int perr, output int done_dt);
        logic hold;
        logic [W-1:0] hp;
        logic [IW-1:0] hi;
        logic [3:0] hd;
        logic rd;
        got = 0; perr = 0; done_dt = -1;
        hold = 1'b0; hp = '0; hi = '0; hd = '0;
        for (int c = 0; c < 8 * NB && done_dt < 0 && got < stop_at; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (hold && (pif.path_valid !== 1'b1 || pif.path !== hp ||
                         pif.path_idx !== hi || pif.day !== hd))
                perr++;
            if (done === 1'b1) begin
                done_dt = cyc - s_cyc;
                if (busy !== 1'b0 || pif.path_valid !== 1'b0) perr++;
            end
            rd = ($urandom_range(99) >= stall_pct);
            pif.path_ready = rd;
            if (got == junk_at && pif.path_valid === 1'b1) begin
                start = 1'b1;
                seed = seed ^ 32'h5a5a_1234;
                s0 = ~s0;
                mu = mu + 12'd77;
            end
            if (pif.path_valid === 1'b1 && rd && got < NB) begin
                obs_path[got] = int'(pif.path);
                obs_idx[got] = int'(pif.path_idx);
                obs_day[got] = int'(pif.day);
                got++;
            end
            hold = (pif.path_valid === 1'b1) && !rd;
            hp = pif.path;
            hi = pif.path_idx;
            hd = pif.day;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pif.path_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pif.path, pif.path_valid, pif.path_idx, pif.day, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got path=%0d valid=%0b idx=%0d day=%0d busy=%0b done=%0b want all 0",
                     pif.path, pif.path_valid, pif.path_idx, pif.day, busy, done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pif.path_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got busy=%0b valid=%0b want 0 0", busy, pif.path_valid);
        end
    endtask

    task automatic test_flat();
        int got, perr, ddt;
        do_start(12'd1000, 12'd0, 8'd0, 32'h1234_5678);
        collect(NB + 1, 0, -1, got, perr, ddt);
        checks++;
        if (got != NB) begin
            errors++;
            $display("FAIL flat_count got %0d want %0d", got, NB);
        end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (obs_path[k] !== 1000 || obs_idx[k] !== k % N || obs_day[k] !== k / N) begin
                errors++;
                $display("FAIL flat_beat %0d got path=%0d idx=%0d day=%0d want path=1000 idx=%0d day=%0d",
                         k, obs_path[k], obs_idx[k], obs_day[k], k % N, k / N);
            end
        end
        checks++;
        if (ddt != NB + 1) begin
            errors++;
            $display("FAIL flat_done_cycle got %0d want %0d", ddt, NB + 1);
        end
        checks++;
        if (perr != 0) begin
            errors++;
            $display("FAIL flat_protocol got %0d violations want 0", perr);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flat_done_pulse got done=%0b busy=%0b want 0 0", done, busy);
        end
    endtask

    task automatic test_drift();
        int got, perr, ddt;
        int want[3];
        want = '{1088, 1156, 1228};
        model_run(1024, 256, 0, 32'hcafe_f00d);
        do_start(12'd1024, 12'd256, 8'd0, 32'hcafe_f00d);
        collect(NB + 1, 10, 50, got, perr, ddt);
        for (int k = 0; k < 3 * N && k < got; k++) begin
            checks++;
            if (obs_path[k] !== want[k / N]) begin
                errors++;
                $display("FAIL drift_day%0d beat %0d got %0d want %0d", k / N, k, obs_path[k], want[k / N]);
            end
        end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (obs_path[k] !== exp_path[k] || obs_idx[k] !== exp_idx[k] || obs_day[k] !== exp_day[k]) begin
                errors++;
                $display("FAIL drift_stream beat %0d got %0d/%0d/%0d want %0d/%0d/%0d", k,
                         obs_path[k], obs_idx[k], obs_day[k], exp_path[k], exp_idx[k], exp_day[k]);
            end
        end
        checks++;
        if (got != NB || ddt < 0 || perr != 0) begin
            errors++;
            $display("FAIL drift_run got beats=%0d done_dt=%0d perr=%0d want %0d >=0 0", got, ddt, perr, NB);
        end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int got, perr, ddt;
        do_start(12'd4000, 12'd2047, 8'd0, 32'h0);
        collect(NB + 1, 0, -1, got, perr, ddt);
        checks++;
        if (got != NB || ddt != NB + 1) begin
            errors++;
            $display("FAIL sat_run got beats=%0d done_dt=%0d want %0d %0d", got, ddt, NB, NB + 1);
        end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (obs_path[k] !== SMAX) begin
                errors++;
                $display("FAIL sat_beat %0d got %0d want %0d", k, obs_path[k], SMAX);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random_stall();
        int got, perr, ddt, m, sv;
        logic [31:0] sd;
        for (int r = 0; r < 2; r++) begin
            m = int'($urandom_range(400)) - 200;
            sv = 500 + int'($urandom_range(3000));
            sd = $urandom;
            model_run(sv, m, 40, sd);
            do_start(W'(sv), 12'(m), 8'd40, sd);
            collect(NB + 1, (r == 0) ? 30 : 60, 300, got, perr, ddt);
            checks++;
            if (got != NB || ddt < 0) begin
                errors++;
                $display("FAIL stall_run%0d got beats=%0d done_dt=%0d want %0d >=0", r, got, ddt, NB);
            end
            checks++;
            if (perr != 0) begin
                errors++;
                $display("FAIL stall_hold%0d got %0d violations want 0", r, perr);
            end
            for (int k = 0; k < got; k++) begin
                checks++;
                if (obs_path[k] !== exp_path[k] || obs_idx[k] !== exp_idx[k] || obs_day[k] !== exp_day[k]) begin
                    errors++;
                    $display("FAIL stall_stream%0d beat %0d got %0d/%0d/%0d want %0d/%0d/%0d", r, k,
                             obs_path[k], obs_idx[k], obs_day[k], exp_path[k], exp_idx[k], exp_day[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        int got, perr, ddt;
        int first[N];
        logic [31:0] sd;
        sd = $urandom;
        model_run(2000, 100, 120, sd);
        do_start(12'd2000, 12'd100, 8'd120, sd);
        collect(3 * N + 5, 20, -1, got, perr, ddt);
        for (int k = 0; k < N; k++) first[k] = obs_path[k];
        checks++;
        if (got != 3 * N + 5 || pif.day !== 4'd3) begin
            errors++;
            $display("FAIL midrst_reach got beats=%0d day=%0d want %0d 3", got, pif.day, 3 * N + 5);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pif.path, pif.path_valid, pif.path_idx, pif.day, busy, done} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got path=%0d valid=%0b idx=%0d day=%0d busy=%0b done=%0b want all 0",
                     pif.path, pif.path_valid, pif.path_idx, pif.day, busy, done);
        end
        rst = 1'b0;
        do_start(12'd2000, 12'd100, 8'd120, sd);
        collect(NB + 1, 20, -1, got, perr, ddt);
        checks++;
        if (got != NB || ddt < 0 || perr != 0) begin
            errors++;
            $display("FAIL midrst_rerun got beats=%0d done_dt=%0d perr=%0d want %0d >=0 0", got, ddt, perr, NB);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs_path[k] !== first[k] || obs_path[k] !== exp_path[k]) begin
                errors++;
                $display("FAIL midrst_day0 beat %0d got %0d first_run %0d want %0d", k, obs_path[k], first[k], exp_path[k]);
            end
        end
        @(negedge clk);
    endtask

`ifdef MC_ANTITHETIC_EN
    task automatic test_antithetic();
        int got, perr, ddt, de, dd;
        model_run(2048, 0, 255, 32'h0bad_beef);
        do_start(12'd2048, 12'd0, 8'd255, 32'h0bad_beef);
        collect(NB + 1, 15, -1, got, perr, ddt);
        for (int k = 0; k + 1 < N && k + 1 < got; k += 2) begin
            de = obs_path[k] - 2048;
            dd = obs_path[k + 1] - 2048;
            checks++;
            if (de * dd > 0 || de + dd > 1 || de + dd < -1) begin
                errors++;
                $display("FAIL anti_pair %0d got dev %0d and %0d want opposite sign, |sum|<=1", k, de, dd);
            end
        end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (obs_path[k] !== exp_path[k]) begin
                errors++;
                $display("FAIL anti_stream beat %0d got %0d want %0d", k, obs_path[k], exp_path[k]);
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        pif.path_ready = 1'b0;
        test_reset();
        test_flat();
        test_drift();
        test_saturate();
        test_random_stall();
        test_mid_reset();
`ifdef MC_ANTITHETIC_EN
        test_antithetic();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got time limit reached want run complete");
        $fatal(1);
    end
endmodule
